// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Contents: default data width and register count, the data and register
// index types, and the CLEAR/RUN state encoding of the clear engine.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_N_REG  = 32;

    typedef logic [RF_DATA_W-1:0]         data_t;
    typedef logic [$clog2(RF_N_REG)-1:0]  reg_t;

    // Clear engine states: CLEAR zeroes one entry per cycle, RUN serves traffic.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback and the multi-port register file.
// Signals:
//   rnum/rd/busy    : read indices, read data, pending-write bit per read port
//   wen/wnum/wd     : write enables, indices and data per write port
//   rsv_en/rsv_num  : scoreboard reservation request
// Modports: master drives requests (issue/writeback side), slave is the file.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int N_REG  = RF_N_REG,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2
);
    localparam int REG_W = $clog2(N_REG);

    logic [N_RD-1:0][REG_W-1:0]  rnum;
    logic [N_RD-1:0][DATA_W-1:0] rd;
    logic [N_RD-1:0]             busy;
    logic [N_WR-1:0]             wen;
    logic [N_WR-1:0][REG_W-1:0]  wnum;
    logic [N_WR-1:0][DATA_W-1:0] wd;
    logic                        rsv_en;
    logic [REG_W-1:0]            rsv_num;

    modport master (
        output rnum, wen, wnum, wd, rsv_en, rsv_num,
        input  rd, busy
    );

    modport slave (
        input  rnum, wen, wnum, wd, rsv_en, rsv_num,
        output rd, busy
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset (clears all bits)
//   i_run            : file is in RUN; reservations and clears ignored otherwise
//   i_wen, i_wnum    : qualified write enables and indices (clear busy)
//   i_rsv_en/_num    : reservation (sets busy); a same-cycle clear loses
//   i_rnum, o_busy   : per read port lookup of the registered bits
module rf_scoreboard #(
    parameter int N_REG = 32,
    parameter int N_RD  = 2,
    parameter int N_WR  = 2,
    localparam int REG_W = $clog2(N_REG)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_run,
    input  logic [N_WR-1:0]            i_wen,
    input  logic [N_WR-1:0][REG_W-1:0] i_wnum,
    input  logic                       i_rsv_en,
    input  logic [REG_W-1:0]           i_rsv_num,
    input  logic [N_RD-1:0][REG_W-1:0] i_rnum,
    output logic [N_RD-1:0]            o_busy
);

    logic [N_REG-1:0] r_busy;
    logic [N_REG-1:0] w_clr;
    logic [N_REG-1:0] w_set;
    logic [N_REG-1:0] w_busy_nxt;

    // Next busy vector: clears applied first so a same-cycle reservation wins; x0 never busy.
    always_comb begin
        w_clr = {N_REG{1'b0}};
        for (int j = 0; j < N_WR; j++) begin
            w_clr = w_clr | (i_wen[j] ? (N_REG'(1) << i_wnum[j]) : {N_REG{1'b0}});
        end
        w_set = (i_rsv_en && (i_rsv_num != {REG_W{1'b0}})) ? (N_REG'(1) << i_rsv_num)
                                                           : {N_REG{1'b0}};
        w_busy_nxt = i_run ? (((r_busy & ~w_clr) | w_set) & ~N_REG'(1)) : r_busy;
    end

    // Busy bit storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= {N_REG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per read port lookup of the registered state.
    always_comb begin
        o_busy = {N_RD{1'b0}};
        for (int k = 0; k < N_RD; k++) begin
            o_busy[k] = r_busy[i_rnum[k]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard.
// After reset a clear engine writes zero to one entry per cycle, so the
// array itself carries no reset and maps onto RAM/LUT-RAM.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (restarts the clear)
//   o_ready      : high once every entry has been cleared
//   io_rf        : read/write/reservation bundle (regfile_mp_if.slave)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to
// the read ports (and mask the matching busy bit); otherwise reads return the
// array contents and o_busy shows the registered scoreboard bit.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int N_REG  = RF_N_REG,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_ready,
    regfile_mp_if.slave   io_rf
);

    localparam int REG_W = $clog2(N_REG);

    state_t                      r_state;
    logic [REG_W-1:0]            r_cnt;
    logic                        r_ready;
    logic [DATA_W-1:0]           r_mem [N_REG];
    logic                        w_run;
    logic [N_WR-1:0]             w_wen;
    logic [N_RD-1:0]             w_sb_busy;
    logic [N_RD-1:0][DATA_W-1:0] w_rd;
    logic [N_RD-1:0]             w_busy;

    assign w_run   = (r_state == ST_RUN);
    assign o_ready = r_ready;

    // Qualified write enables: only in RUN, index 0 discarded.
    always_comb begin
        w_wen = {N_WR{1'b0}};
        for (int j = 0; j < N_WR; j++) begin
            w_wen[j] = io_rf.wen[j] & w_run & (io_rf.wnum[j] != {REG_W{1'b0}});
        end
    end

    // Clear engine FSM: N_REG clearing edges after reset release, then RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= {REG_W{1'b0}};
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + REG_W'(1);
                    if (r_cnt == REG_W'(N_REG - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= {REG_W{1'b0}};
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: clear-engine zeroing or port writes; higher port index assigned last wins.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            if (!i_rst) begin
                r_mem[r_cnt] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int j = 0; j < N_WR; j++) begin
                if (w_wen[j]) begin
                    r_mem[io_rf.wnum[j]] <= io_rf.wd[j];
                end
            end
        end
    end

    rf_scoreboard #(
        .N_REG (N_REG),
        .N_RD  (N_RD),
        .N_WR  (N_WR)
    ) u_sb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_run     (w_run),
        .i_wen     (w_wen),
        .i_wnum    (io_rf.wnum),
        .i_rsv_en  (io_rf.rsv_en),
        .i_rsv_num (io_rf.rsv_num),
        .i_rnum    (io_rf.rnum),
        .o_busy    (w_sb_busy)
    );

    // Read ports: zero in CLEAR and for x0, optional same-cycle write forwarding.
    always_comb begin
        w_rd   = {(N_RD*DATA_W){1'b0}};
        w_busy = {N_RD{1'b0}};
        for (int k = 0; k < N_RD; k++) begin
            if (w_run && (io_rf.rnum[k] != {REG_W{1'b0}})) begin
                w_rd[k]   = r_mem[io_rf.rnum[k]];
                w_busy[k] = w_sb_busy[k];
            end else begin
                w_rd[k]   = {DATA_W{1'b0}};
                w_busy[k] = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            // w_wen already excludes x0 and CLEAR; later ports override earlier ones.
            for (int j = 0; j < N_WR; j++) begin
                w_rd[k]   = (w_wen[j] && (io_rf.wnum[j] == io_rf.rnum[k])) ? io_rf.wd[j] : w_rd[k];
                w_busy[k] = (w_wen[j] && (io_rf.wnum[j] == io_rf.rnum[k])) ? 1'b0 : w_busy[k];
            end
`endif
        end
    end

    assign io_rf.rd   = w_rd;
    assign io_rf.busy = w_busy;

endmodule
